// File: rtl/pmod_adc_arbiter.sv
// Four-requester round-robin front end for a PMOD SPI ADC.
// Each grant runs one 16-bit command/response frame, then holds cs high for a minimum gap.
module pmod_adc_arbiter #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [7:0]  req_ch,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [11:0] data,
    output logic        busy,
    output logic        cs,
    output logic        sclk,
    output logic        din,
    input  logic        dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE,
        S_GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  ptr;
    logic [1:0]  win_idx;
    logic [1:0]  scan_idx;
    logic        win_found;
    logic [1:0]  ch;
    logic [7:0]  div_cnt;
    logic [7:0]  gap_cnt;
    logic [3:0]  bit_cnt;
    logic [11:0] rx_sr;
    logic [15:0] cmd_word;
    logic        div_last;
    logic        shift_end;

    assign cmd_word  = {2'b11, ch, 12'b0};
    assign div_last  = (div_cnt == DIV_LAST);
    assign shift_end = div_last && sclk && (bit_cnt == 4'd15);

    // Scan upward from the pointer; 2-bit addition wraps modulo 4.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win_found = 1'b0;
        win_idx   = ptr;
        scan_idx  = ptr;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr + 2'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_found) state_nxt = S_SHIFT;
            S_SHIFT: if (shift_end) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_GAP;
            S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // Only the low 12 of the 16 received bits are kept; after 16 shifts they are the result field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            gnt     <= 4'b0;
            done    <= 4'b0;
            data    <= 12'b0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            din     <= 1'b0;
            ptr     <= 2'd0;
            ch      <= 2'd0;
            div_cnt <= 8'd0;
            gap_cnt <= 8'd0;
            bit_cnt <= 4'd0;
            rx_sr   <= 12'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        gnt     <= 4'b0001 << win_idx;
                        ch      <= req_ch[{win_idx, 1'b0} +: 2];
                        ptr     <= win_idx + 2'd1;
                        cs      <= 1'b0;
                        sclk    <= 1'b0;
                        din     <= 1'b1;
                        div_cnt <= 8'd0;
                        bit_cnt <= 4'd0;
                    end
                end
                S_SHIFT: begin
                    if (div_last) begin
                        div_cnt <= 8'd0;
                        if (!sclk) begin
                            sclk  <= 1'b1;
                            rx_sr <= {rx_sr[10:0], dout};
                        end else if (bit_cnt == 4'd15) begin
                            sclk <= 1'b0;
                            cs   <= 1'b1;
                            data <= rx_sr;
                            done <= gnt;
                            gnt  <= 4'b0;
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + 4'd1;
                            din     <= cmd_word[4'd14 - bit_cnt];
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    done    <= 4'b0;
                    gap_cnt <= 8'd0;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: begin
                    done <= 4'b0;
                end
            endcase
        end
    end

endmodule
